// File: rtl/music_cal_pkg.sv
// Shared definitions for the calculator datapath: opcodes, FSM states,
// datapath widths and the keypad key codes used by the entry stage.
package music_cal_pkg;

  localparam int DIGW     = 4;
  localparam int BINW     = 8;
  localparam int BCD_ITER = 8;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_CMP = 3'd4;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_AND = 4'hC;
  localparam logic [3:0] KEY_OR  = 4'hD;
  localparam logic [3:0] KEY_CMP = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CONV  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_SHIFT = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Tens digit to binary using only shifts and one add.
  function automatic logic [BINW-1:0] times10(input logic [DIGW-1:0] x);
    logic [BINW-1:0] w;
    w = BINW'(x);
    return (w << 3) + (w << 1);
  endfunction

endpackage

// File: rtl/bcd_alu_exec_bin2bcd_seq.sv
// Iterative double-dabble: one add-3/shift step per cycle, three BCD digits out.
module bin2bcd_seq #(
  parameter int DATA_W = 8,
  parameter int STAGES = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] bin_i,
  output logic              last_o,
  output logic [3:0]        bcd2_o,
  output logic [3:0]        bcd1_o,
  output logic [3:0]        bcd0_o
);

  localparam int SRW  = DATA_W + 12;
  localparam int CNTW = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic [SRW-1:0]  sr_q;
  logic [SRW-1:0]  sr_d;
  logic [CNTW-1:0] cnt_q;
  logic            busy_q;
  logic [11:0]     dig_q;

  function automatic logic [SRW-1:0] dabble_step(input logic [SRW-1:0] v);
    logic [SRW-1:0] t;
    t = v;
    for (int k = 0; k < 3; k++) begin
      if (t[DATA_W + 4*k +: 4] >= 4'd5)
        t[DATA_W + 4*k +: 4] = t[DATA_W + 4*k +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  assign sr_d   = dabble_step(sr_q);
  assign last_o = busy_q && (cnt_q == CNTW'(STAGES - 1));
  assign bcd2_o = dig_q[11:8];
  assign bcd1_o = dig_q[7:4];
  assign bcd0_o = dig_q[3:0];

  // Load on start, then step once per cycle; the final step also publishes the digits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      dig_q  <= '0;
    end else if (start_i) begin
      sr_q   <= {12'd0, bin_i};
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      sr_q  <= sr_d;
      cnt_q <= cnt_q + CNTW'(1);
      if (last_o) begin
        busy_q <= 1'b0;
        dig_q  <= sr_d[SRW-1:DATA_W];
      end
    end
  end

endmodule

// File: rtl/bcd_alu_exec.sv
// Two-digit BCD ALU: latch operands, convert to binary, execute, and
// convert the magnitude back to three BCD digits with a busy/done handshake.
import music_cal_pkg::*;

module bcd_alu_exec (
  input  logic            IN_clk,
  input  logic            IN_reset,
  input  logic [DIGW-1:0] IN_SRCH,
  input  logic [DIGW-1:0] IN_SRCL,
  input  logic [DIGW-1:0] IN_DSTH,
  input  logic [DIGW-1:0] IN_DSTL,
  input  logic [2:0]      IN_ALU_OP,
  input  logic            IN_finish,
  output logic            OUT_busy,
  output logic            OUT_done,
  output logic [DIGW-1:0] OUT_RES2,
  output logic [DIGW-1:0] OUT_RES1,
  output logic [DIGW-1:0] OUT_RES0,
  output logic            OUT_neg,
  output logic            OUT_zero,
  output logic            OUT_err
);

  state_t          state_q, state_d;
  logic [DIGW-1:0] srch_q, srcl_q, dsth_q, dstl_q;
  logic [2:0]      op_q;
  logic            err_q;
  logic [BINW-1:0] src_q, dst_q;
  logic [BINW-1:0] res_q, res_d;
  logic            neg_q, neg_d, zero_q, zero_d;
  logic            out_neg_q, out_zero_q, out_err_q;
  logic            dd_start, dd_last;

  // State register.
  always_ff @(posedge IN_clk) begin
    if (IN_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; the conversion engine decides when SHIFT ends.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (IN_finish) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_CONV;
      ST_CONV:  state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_SHIFT;
      ST_SHIFT: if (dd_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    OUT_busy = (state_q != ST_IDLE);
    OUT_done = (state_q == ST_DONE);
    dd_start = (state_q == ST_EXEC);
  end

  // Operation result; an error forces everything to zero.
  always_comb begin
    res_d  = '0;
    neg_d  = 1'b0;
    zero_d = 1'b0;
    if (!err_q) begin
      case (op_q)
        OP_ADD: res_d = src_q + dst_q;
        OP_SUB: begin
          neg_d = (src_q < dst_q);
          res_d = neg_d ? (dst_q - src_q) : (src_q - dst_q);
        end
        OP_AND: res_d = src_q & dst_q;
        OP_OR:  res_d = src_q | dst_q;
        OP_CMP: begin
          neg_d  = (src_q < dst_q);
          zero_d = (src_q == dst_q);
        end
        default: res_d = '0;
      endcase
      if (op_q != OP_CMP) zero_d = (res_d == '0);
    end
  end

  // Datapath registers, one group per FSM state.
  always_ff @(posedge IN_clk) begin
    if (IN_reset) begin
      srch_q <= '0; srcl_q <= '0; dsth_q <= '0; dstl_q <= '0; op_q <= '0;
      err_q <= 1'b0; src_q <= '0; dst_q <= '0;
      res_q <= '0; neg_q <= 1'b0; zero_q <= 1'b0;
      out_neg_q <= 1'b0; out_zero_q <= 1'b0; out_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (IN_finish) begin
          srch_q <= IN_SRCH; srcl_q <= IN_SRCL;
          dsth_q <= IN_DSTH; dstl_q <= IN_DSTL;
          op_q   <= IN_ALU_OP;
        end
        ST_LOAD: err_q <= (srch_q > 4'd9) || (srcl_q > 4'd9) || (dsth_q > 4'd9) ||
                          (dstl_q > 4'd9) || (op_q > OP_CMP);
        ST_CONV: begin
          src_q <= times10(srch_q) + BINW'(srcl_q);
          dst_q <= times10(dsth_q) + BINW'(dstl_q);
        end
        ST_EXEC: begin
          res_q  <= res_d;
          neg_q  <= neg_d;
          zero_q <= zero_d;
        end
        ST_SHIFT: if (dd_last) begin
          out_neg_q  <= neg_q;
          out_zero_q <= zero_q;
          out_err_q  <= err_q;
        end
        default: ;
      endcase
    end
  end

  assign OUT_neg  = out_neg_q;
  assign OUT_zero = out_zero_q;
  assign OUT_err  = out_err_q;

  bin2bcd_seq #(
    .DATA_W (BINW),
    .STAGES (BCD_ITER)
  ) u_bin2bcd (
    .clk_i   (IN_clk),
    .rst_i   (IN_reset),
    .start_i (dd_start),
    .bin_i   (res_d),
    .last_o  (dd_last),
    .bcd2_o  (OUT_RES2),
    .bcd1_o  (OUT_RES1),
    .bcd0_o  (OUT_RES0)
  );

endmodule

// File: tb/tb_bcd_alu_exec.sv
// Directed and randomized checks of the BCD ALU against an arithmetic model.
module tb_bcd_alu_exec;

  logic       IN_clk = 1'b0;
  logic       IN_reset = 1'b1;
  logic [3:0] IN_SRCH = '0, IN_SRCL = '0, IN_DSTH = '0, IN_DSTL = '0;
  logic [2:0] IN_ALU_OP = '0;
  logic       IN_finish = 1'b0;
  logic       OUT_busy, OUT_done, OUT_neg, OUT_zero, OUT_err;
  logic [3:0] OUT_RES2, OUT_RES1, OUT_RES0;

  int n_vec = 0;
  int n_bad = 0;

  bcd_alu_exec dut (
    .IN_clk(IN_clk), .IN_reset(IN_reset),
    .IN_SRCH(IN_SRCH), .IN_SRCL(IN_SRCL), .IN_DSTH(IN_DSTH), .IN_DSTL(IN_DSTL),
    .IN_ALU_OP(IN_ALU_OP), .IN_finish(IN_finish),
    .OUT_busy(OUT_busy), .OUT_done(OUT_done),
    .OUT_RES2(OUT_RES2), .OUT_RES1(OUT_RES1), .OUT_RES0(OUT_RES0),
    .OUT_neg(OUT_neg), .OUT_zero(OUT_zero), .OUT_err(OUT_err)
  );

  always #5 IN_clk = ~IN_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain decimal arithmetic on the two-digit operands.
  task automatic model(input int sh, input int sl, input int dh, input int dl, input int op,
                       output int res, output bit neg, output bit zero, output bit err);
    int s, d;
    s = sh * 10 + sl;
    d = dh * 10 + dl;
    err = (sh > 9) || (sl > 9) || (dh > 9) || (dl > 9) || (op > 4);
    res = 0; neg = 0; zero = 0;
    if (!err) begin
      case (op)
        0: res = s + d;
        1: begin res = (s >= d) ? s - d : d - s; neg = (s < d); end
        2: res = s & d;
        3: res = s | d;
        default: begin res = 0; neg = (s < d); end
      endcase
      zero = (op == 4) ? (s == d) : (res == 0);
    end
  endtask

  task automatic drive(input int sh, input int sl, input int dh, input int dl, input int op);
    IN_SRCH = 4'(sh); IN_SRCL = 4'(sl); IN_DSTH = 4'(dh); IN_DSTL = 4'(dl);
    IN_ALU_OP = 3'(op);
  endtask

  // Launch one operation, time its done pulse, then compare all results.
  task automatic run_op(input string tag, input int sh, input int sl, input int dh,
                        input int dl, input int op);
    int res, cyc;
    bit neg, zero, err;
    model(sh, sl, dh, dl, op, res, neg, zero, err);
    drive(sh, sl, dh, dl, op);
    IN_finish = 1'b1;
    @(posedge IN_clk); #1;
    IN_finish = 1'b0;
    cyc = 1;
    check({tag, ".busy1"}, 32'(OUT_busy), 32'd1);
    while (!OUT_done && cyc < 30) begin
      @(posedge IN_clk); #1;
      cyc++;
    end
    check({tag, ".latency"}, 32'(cyc), 32'd12);
    check({tag, ".res"}, {20'd0, OUT_RES2, OUT_RES1, OUT_RES0},
          {20'd0, 4'(res / 100), 4'((res / 10) % 10), 4'(res % 10)});
    check({tag, ".flags"}, {29'd0, OUT_neg, OUT_zero, OUT_err}, {29'd0, neg, zero, err});
    @(posedge IN_clk); #1;
    check({tag, ".donepulse"}, {30'd0, OUT_done, OUT_busy}, 32'd0);
  endtask

  initial begin
    int dones, res;
    bit neg, zero, err;

    repeat (2) @(posedge IN_clk);
    #1;
    check("reset.outs", {18'd0, OUT_busy, OUT_done, OUT_RES2, OUT_RES1, OUT_RES0,
                         OUT_neg, OUT_zero, OUT_err}, 32'd0);
    IN_reset = 1'b0;
    @(posedge IN_clk); #1;

    run_op("add12_34", 1, 2, 3, 4, 0);
    run_op("add99_99", 9, 9, 9, 9, 0);
    run_op("add00_00", 0, 0, 0, 0, 0);
    run_op("sub05_23", 0, 5, 2, 3, 1);
    run_op("sub23_05", 2, 3, 0, 5, 1);
    run_op("and12_10", 1, 2, 1, 0, 2);
    run_op("or12_10",  1, 2, 1, 0, 3);
    run_op("cmp42_42", 4, 2, 4, 2, 4);
    run_op("cmp07_42", 0, 7, 4, 2, 4);
    run_op("cmp42_07", 4, 2, 0, 7, 4);
    run_op("errdigit", 1, 10, 3, 4, 0);
    run_op("errop",    1, 2, 3, 4, 6);
    run_op("sub_eq",   5, 5, 5, 5, 1);

    // Extra strobe while busy must be ignored.
    model(3, 1, 1, 9, 0, res, neg, zero, err);
    drive(3, 1, 1, 9, 0);
    IN_finish = 1'b1;
    @(posedge IN_clk); #1;
    IN_finish = 1'b0;
    repeat (2) @(posedge IN_clk);
    #1;
    drive(9, 9, 9, 9, 0);
    IN_finish = 1'b1;
    @(posedge IN_clk); #1;
    IN_finish = 1'b0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge IN_clk); #1;
      if (OUT_done) begin
        dones++;
        check("retrig.res", {20'd0, OUT_RES2, OUT_RES1, OUT_RES0},
              {20'd0, 4'(res / 100), 4'((res / 10) % 10), 4'(res % 10)});
      end
    end
    check("retrig.dones", 32'(dones), 32'd1);

    // Strobe held for several cycles starts one operation only.
    drive(4, 4, 2, 2, 1);
    IN_finish = 1'b1;
    repeat (5) @(posedge IN_clk);
    #1;
    IN_finish = 1'b0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge IN_clk); #1;
      if (OUT_done) dones++;
    end
    check("held.dones", 32'(dones), 32'd1);

    // Reset mid-operation aborts with no done and clears outputs.
    drive(7, 7, 1, 1, 0);
    IN_finish = 1'b1;
    @(posedge IN_clk); #1;
    IN_finish = 1'b0;
    repeat (4) @(posedge IN_clk);
    #1;
    IN_reset = 1'b1;
    @(posedge IN_clk); #1;
    IN_reset = 1'b0;
    check("abort.outs", {18'd0, OUT_busy, OUT_done, OUT_RES2, OUT_RES1, OUT_RES0,
                         OUT_neg, OUT_zero, OUT_err}, 32'd0);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge IN_clk); #1;
      if (OUT_done || OUT_busy) dones++;
    end
    check("abort.quiet", 32'(dones), 32'd0);

    // Randomized operands, occasionally illegal digits or opcodes.
    for (int i = 0; i < 40; i++) begin
      int d[4];
      for (int k = 0; k < 4; k++)
        d[k] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15))
                                           : int'($urandom_range(0, 9));
      run_op("rand", d[0], d[1], d[2], d[3], int'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
